// File: rtl/tqvp_xoshiro_fifo.sv
// xoshiro128++ random word generator feeding a small FIFO behind a TinyQV-style register bus.
// Define XOSHIRO_JUMP_EN to build the 2^64-step jump engine (CTRL.JUMP); without it JUMP is ignored.
module tqvp_xoshiro_fifo #(
  parameter int           FIFO_DEPTH = 4,
  parameter logic [127:0] RESET_SEED = 128'h00000004_00000003_00000002_00000001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam int         PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] DEPTH_L = 5'(FIFO_DEPTH);

  localparam logic [5:0] ADDR_RND    = 6'h00;
  localparam logic [5:0] ADDR_SEED0  = 6'h04;
  localparam logic [5:0] ADDR_SEED1  = 6'h08;
  localparam logic [5:0] ADDR_SEED2  = 6'h0C;
  localparam logic [5:0] ADDR_SEED3  = 6'h10;
  localparam logic [5:0] ADDR_CTRL   = 6'h14;
  localparam logic [5:0] ADDR_STATUS = 6'h18;

  function automatic logic [127:0] xo_step(input logic [127:0] s);
    logic [31:0] s0, s1, s2, s3, t;
    s0 = s[31:0];
    s1 = s[63:32];
    s2 = s[95:64];
    s3 = s[127:96];
    t  = s1 << 9;
    s2 = s2 ^ s0;
    s3 = s3 ^ s1;
    s1 = s1 ^ s2;
    s0 = s0 ^ s3;
    s2 = s2 ^ t;
    s3 = {s3[20:0], s3[31:21]};
    return {s3, s2, s1, s0};
  endfunction

  logic [127:0]     state;
  logic [3:0][31:0] seed_shadow;
  logic             en, ie;
  logic [3:0]       thr;
  logic             busy, jump_start;

  logic [31:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [4:0]       level;
  logic             empty, full, push, pop, flush;

  logic             read_done;
  logic [31:0]      read_word;

  logic [31:0]      gen_sum, gen_out;
  logic             wr_any, wr32, rd_any, rd32_rnd, rnd_sel, ctrl_wr, seed_load;
  logic             unused_ok;

  assign unused_ok = &{1'b0, ui_in};
  assign uo_out    = 8'h00;

  assign gen_sum = state[31:0] + state[127:96];
  assign gen_out = {gen_sum[24:0], gen_sum[31:25]} + state[31:0];

  assign wr_any    = (data_write_n != 2'b11);
  assign wr32      = (data_write_n == 2'b10);
  assign rd_any    = (data_read_n != 2'b11);
  assign rnd_sel   = (address == ADDR_RND);
  assign rd32_rnd  = rnd_sel && (data_read_n == 2'b10);
  assign ctrl_wr   = wr_any && (address == ADDR_CTRL);
  assign seed_load = wr32 && (address == ADDR_SEED3) && !busy;
  assign flush     = seed_load || jump_start;

  assign empty = (level == 5'd0);
  assign full  = (level == DEPTH_L);
  // A 32-bit RND transaction pops once; the remaining cycles replay read_word.
  assign pop   = rd32_rnd && !read_done && !busy && !empty;
  assign push  = en && !busy && !flush && (!full || pop);

`ifdef XOSHIRO_JUMP_EN
  localparam logic [127:0] JUMP_POLY = 128'h77f2db5b_6fa035c3_f542d2d3_8764000b;

  logic [6:0]   jump_cnt;
  logic [127:0] jump_acc, jump_acc_nxt;

  assign jump_start   = ctrl_wr && data_in[2] && !busy;
  assign jump_acc_nxt = JUMP_POLY[jump_cnt] ? (jump_acc ^ state) : jump_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      jump_cnt <= 7'd0;
      jump_acc <= '0;
    end else if (jump_start) begin
      busy     <= 1'b1;
      jump_cnt <= 7'd0;
      jump_acc <= '0;
    end else if (busy) begin
      jump_acc <= jump_acc_nxt;
      jump_cnt <= jump_cnt + 7'd1;
      if (jump_cnt == 7'd127) busy <= 1'b0;
    end
  end
`else
  assign busy       = 1'b0;
  assign jump_start = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET_SEED;
    end else if (seed_load) begin
      state <= {data_in, seed_shadow[2:0]};
`ifdef XOSHIRO_JUMP_EN
    end else if (busy) begin
      state <= (jump_cnt == 7'd127) ? jump_acc_nxt : xo_step(state);
`endif
    end else if (push) begin
      state <= xo_step(state);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_shadow <= RESET_SEED;
      en          <= 1'b1;
      ie          <= 1'b0;
      thr         <= 4'd0;
    end else begin
      if (wr32 && !busy) begin
        case (address)
          ADDR_SEED0: seed_shadow[0] <= data_in;
          ADDR_SEED1: seed_shadow[1] <= data_in;
          ADDR_SEED2: seed_shadow[2] <= data_in;
          ADDR_SEED3: seed_shadow[3] <= data_in;
          default: ;
        endcase
      end
      if (ctrl_wr) begin
        en  <= data_in[0];
        ie  <= data_in[1];
        thr <= data_in[7:4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= 5'd0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= 5'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + 5'(push) - 5'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= gen_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_done <= 1'b0;
      read_word <= 32'h0;
    end else if (!rd32_rnd) begin
      read_done <= 1'b0;
    end else if (!read_done && data_ready) begin
      read_done <= 1'b1;
      read_word <= data_out;
    end
  end

  always_comb begin
    data_out   = 32'h0;
    data_ready = 1'b0;
    if (rd_any) begin
      if (rnd_sel) begin
        if (read_done && rd32_rnd) begin
          data_out   = read_word;
          data_ready = 1'b1;
        end else if (busy) begin
          data_ready = 1'b0;
        end else if (!empty) begin
          data_out   = fifo_mem[rd_ptr];
          data_ready = 1'b1;
        end else if (!en) begin
          data_ready = 1'b1;
        end
      end else begin
        data_ready = 1'b1;
        case (address)
          ADDR_SEED0:  data_out = seed_shadow[0];
          ADDR_SEED1:  data_out = seed_shadow[1];
          ADDR_SEED2:  data_out = seed_shadow[2];
          ADDR_SEED3:  data_out = seed_shadow[3];
          ADDR_CTRL:   data_out = {24'h0, thr, 2'b00, ie, en};
          ADDR_STATUS: data_out = {24'h0, busy, full, empty, level};
          default:     data_out = 32'h0;
        endcase
      end
    end
  end

  assign user_interrupt = ie && (level >= {1'b0, thr}) && (thr != 4'd0);

endmodule

// File: tb/tb_tqvp_xoshiro_fifo.sv
// Randomised bench for tqvp_xoshiro_fifo; the reference is a software xoshiro128++ stream.
// Jump expectations follow the XOSHIRO_JUMP_EN define, matching the RTL build.
module tb_tqvp_xoshiro_fifo;

  localparam int DEPTH = 4;

  localparam logic [5:0] A_RND    = 6'h00;
  localparam logic [5:0] A_SEED0  = 6'h04;
  localparam logic [5:0] A_SEED1  = 6'h08;
  localparam logic [5:0] A_SEED2  = 6'h0C;
  localparam logic [5:0] A_SEED3  = 6'h10;
  localparam logic [5:0] A_CTRL   = 6'h14;
  localparam logic [5:0] A_STATUS = 6'h18;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ui_in;
  logic [7:0]  uo_out;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  int checks = 0;
  int errors = 0;

  // Software state whose output is the next word a 32-bit RND read must return.
  logic [127:0] model_state;

  tqvp_xoshiro_fifo #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
    .address(address), .data_in(data_in),
    .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(data_out), .data_ready(data_ready), .user_interrupt(user_interrupt)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] ref_next(input logic [127:0] s);
    logic [31:0] s0, s1, s2, s3, t;
    s0 = s[31:0]; s1 = s[63:32]; s2 = s[95:64]; s3 = s[127:96];
    t = s1 << 9;
    s2 ^= s0; s3 ^= s1; s1 ^= s2; s0 ^= s3; s2 ^= t;
    s3 = (s3 << 11) | (s3 >> 21);
    return {s3, s2, s1, s0};
  endfunction

  function automatic logic [31:0] ref_word(input logic [127:0] s);
    logic [31:0] sum;
    sum = s[31:0] + s[127:96];
    return ((sum << 7) | (sum >> 25)) + s[31:0];
  endfunction

  function automatic logic [127:0] ref_jump(input logic [127:0] s);
    logic [31:0]  jc [4];
    logic [127:0] acc, cur;
    jc  = '{32'h8764000b, 32'hf542d2d3, 32'h6fa035c3, 32'h77f2db5b};
    acc = '0;
    cur = s;
    for (int i = 0; i < 4; i++)
      for (int b = 0; b < 32; b++) begin
        if (jc[i][b]) acc ^= cur;
        cur = ref_next(cur);
      end
    return acc;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [5:0] addr, input logic [31:0] data, input logic [1:0] wn);
    @(posedge clk); #1;
    address = addr; data_in = data; data_write_n = wn;
    @(posedge clk); #1;
    data_write_n = 2'b11;
  endtask

  task automatic bus_read(input logic [5:0] addr, input logic [1:0] rn, input int hold,
                          output logic [31:0] data, output int stall);
    logic seen;
    logic [31:0] got;
    seen = 1'b0; got = 32'h0; stall = 0;
    @(posedge clk); #1;
    address = addr; data_read_n = rn;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (data_ready) begin
        seen = 1'b1;
        got  = data_out;
        break;
      end
      stall++;
      @(posedge clk); #1;
    end
    checkOutput("read_timeout", 32'(seen), 32'd1);
    for (int h = 1; h < hold; h++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("hold_ready", 32'(data_ready), 32'd1);
      checkOutput("hold_data", data_out, got);
    end
    @(posedge clk); #1;
    data_read_n = 2'b11;
    data = got;
  endtask

  task automatic rnd_read(input string tag, input int hold, output logic [31:0] data, output int stall);
    bus_read(A_RND, 2'b10, hold, data, stall);
    checkOutput(tag, data, ref_word(model_state));
    model_state = ref_next(model_state);
  endtask

  task automatic write_seeds(input logic [31:0] s0, s1, s2, s3);
    bus_write(A_SEED0, s0, 2'b10);
    bus_write(A_SEED1, s1, 2'b10);
    bus_write(A_SEED2, s2, 2'b10);
    bus_write(A_SEED3, s3, 2'b10);
    model_state = {s3, s2, s1, s0};
  endtask

  task automatic applyStimulus(input int n);
    logic [31:0] d, s0, s1, s2, s3;
    int st, op;
    for (int i = 0; i < n; i++) begin
      op = int'($urandom_range(0, 9));
      if (op <= 5) begin
        rnd_read("rand_read", int'($urandom_range(1, 4)), d, st);
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end else if (op == 6) begin
        bus_read(A_RND, ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b01, 1, d, st);
        checkOutput("rand_peek", d, ref_word(model_state));
      end else if (op == 7) begin
        repeat (DEPTH + 2) @(posedge clk);
        bus_read(A_STATUS, 2'b10, 1, d, st);
        checkOutput("rand_level", d, 32'h40 | 32'(DEPTH));
      end else if (op == 8) begin
        s0 = $urandom; s1 = $urandom; s2 = $urandom; s3 = $urandom;
        write_seeds(s0, s1, s2, s3);
      end else begin
        bus_read(6'(32'h1C + $urandom_range(0, 35)), 2'b10, 1, d, st);
        checkOutput("rand_unmapped", d, 32'h0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] d;
    int st, busy_cycles, lvl;

    ui_in = 8'(($urandom));
    address = 6'h0; data_in = 32'h0;
    data_write_n = 2'b11; data_read_n = 2'b11;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_uo_out", 32'(uo_out), 32'h0);
    checkOutput("reset_irq", 32'(user_interrupt), 32'h0);
    checkOutput("reset_data_out", data_out, 32'h0);
    address = A_STATUS; data_read_n = 2'b10; #1;
    checkOutput("reset_status", data_out, 32'h20);
    address = A_CTRL; #1;
    checkOutput("reset_ctrl", data_out, 32'h01);
    data_read_n = 2'b11; address = 6'h0;
    @(negedge clk);
    rst_n = 1'b1;
    model_state = 128'h00000004_00000003_00000002_00000001;

    repeat (5) @(posedge clk);
    bus_read(A_STATUS, 2'b10, 1, d, st);
    checkOutput("status_full_after_reset", d, 32'h40 | 32'(DEPTH));
    rnd_read("first_word_model", 1, d, st);
    checkOutput("first_word", d, 32'h00000281);
    rnd_read("second_word_model", 1, d, st);
    checkOutput("second_word", d, 32'h00180387);
    repeat (8) @(posedge clk);
    bus_read(A_STATUS, 2'b10, 1, d, st);
    checkOutput("status_refilled", d, 32'h40 | 32'(DEPTH));

    rnd_read("held_read", 4, d, st);
    rnd_read("after_held_read", 1, d, st);
    rnd_read("after_held_read2", 2, d, st);

    write_seeds(32'd1, 32'd2, 32'd3, 32'd4);
    rnd_read("reseed_first_model", 1, d, st);
    checkOutput("reseed_first", d, 32'h00000281);
    checkOutput("reseed_stall_le1", 32'(st <= 1), 32'd1);
    rnd_read("reseed_second", 1, d, st);

    bus_write(A_SEED0, 32'hFF, 2'b00);
    bus_write(A_SEED1, 32'hFFFF, 2'b01);
    bus_write(A_SEED3, 32'd4, 2'b10);
    model_state = {32'd4, 32'd3, 32'd2, 32'd1};
    rnd_read("narrow_seed_ignored", 1, d, st);
    checkOutput("narrow_seed_word", d, 32'h00000281);

    bus_write(6'h1C, 32'hFFFF_FFFF, 2'b10);
    bus_read(6'h1C, 2'b10, 1, d, st);
    checkOutput("unmapped_read", d, 32'h0);
    bus_read(6'h02, 2'b10, 1, d, st);
    checkOutput("unaligned_read", d, 32'h0);
    bus_read(A_CTRL, 2'b10, 1, d, st);
    checkOutput("ctrl_unchanged", d, 32'h01);

    repeat (8) @(posedge clk);
    bus_write(A_CTRL, 32'h0, 2'b10);
    bus_read(A_STATUS, 2'b10, 1, d, st);
    checkOutput("en0_status_full", d, 32'h40 | 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) rnd_read("drain_read", 1, d, st);
    bus_read(A_STATUS, 2'b10, 1, d, st);
    checkOutput("drained_status", d, 32'h20);
    bus_read(A_RND, 2'b10, 1, d, st);
    checkOutput("empty_en0_data", d, 32'h0);
    checkOutput("empty_en0_no_stall", 32'(st), 32'd0);
    bus_write(A_CTRL, 32'h01, 2'b10);
    rnd_read("refill_resumes", 1, d, st);

    repeat (8) @(posedge clk);
    bus_write(A_CTRL, 32'h33, 2'b10);
    checkOutput("irq_full", 32'(user_interrupt), 32'(DEPTH >= 3));
    bus_write(A_CTRL, 32'h32, 2'b10);
    rnd_read("irq_drain1", 1, d, st);
    rnd_read("irq_drain2", 1, d, st);
    lvl = DEPTH - 2;
    checkOutput("irq_below_thr", 32'(user_interrupt), 32'(lvl >= 3));
    bus_write(A_CTRL, 32'h33, 2'b10);
    checkOutput("irq_before_refill", 32'(user_interrupt), 32'(lvl >= 3));
    @(posedge clk); #1;
    lvl = lvl + 1;
    checkOutput("irq_at_thr", 32'(user_interrupt), 32'(lvl >= 3));
    bus_write(A_CTRL, 32'h03, 2'b10);
    checkOutput("irq_thr_zero", 32'(user_interrupt), 32'h0);
    bus_write(A_CTRL, 32'h01, 2'b10);

    bus_write(A_CTRL, 32'h0, 2'b10);
    write_seeds(32'd1, 32'd2, 32'd3, 32'd4);
    bus_write(A_CTRL, 32'h04, 2'b10);
    busy_cycles = 0;
    address = A_STATUS; data_read_n = 2'b10;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!data_out[7]) break;
      busy_cycles++;
    end
    @(posedge clk); #1;
    data_read_n = 2'b11;
`ifdef XOSHIRO_JUMP_EN
    checkOutput("jump_busy_cycles", 32'(busy_cycles), 32'd128);
    model_state = ref_jump({32'd4, 32'd3, 32'd2, 32'd1});
`else
    checkOutput("jump_busy_cycles", 32'(busy_cycles), 32'd0);
    model_state = {32'd4, 32'd3, 32'd2, 32'd1};
`endif
    bus_write(A_CTRL, 32'h01, 2'b10);
    rnd_read("after_jump_first", 1, d, st);
`ifndef XOSHIRO_JUMP_EN
    checkOutput("no_jump_word", d, 32'h00000281);
`endif
    rnd_read("after_jump_second", 1, d, st);

    applyStimulus(80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tqvp_xoshiro_fifo.md
TQVP_XOSHIRO_FIFO -- requirements
Module: tqvp_xoshiro_fifo

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 4, buffered random words; power of two, 2..16.
REQ-002 SHALL provide parameter RESET_SEED, default 128'h00000004_00000003_00000002_00000001, reset state {s3,s2,s1,s0}.
REQ-003 SHALL have ports: clk  in  1  clock (single clock domain).
REQ-004 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have: ui_in  in  8  unused; uo_out  out  8  tied 0.
REQ-006 SHALL have: address  in  6  byte address; data_in  in  32  write data.
REQ-007 SHALL have: data_write_n  in  2  and data_read_n  in  2  (11 none, 00 8b, 01 16b, 10 32b).
REQ-008 SHALL have: data_out  out  32  read data; data_ready  out  1  read complete; user_interrupt  out  1  level IRQ.

Function
REQ-009 SHALL map 0x00 RND, 0x04/0x08/0x0C/0x10 SEED0..3, 0x14 CTRL, 0x18 STATUS; all other addresses read 0, writes ignored.
REQ-010 SHALL implement xoshiro128++: out = rotl(s0+s3,7)+s0, mod 2^32; state update per standard algorithm, one step per cycle.
REQ-011 SHALL push one output word per cycle while CTRL.EN=1, not busy, and FIFO not full, or FIFO full with a pop that same cycle.
REQ-012 SHALL pop FIFO exactly once per RND 32-bit read transaction (consecutive cycles with data_read_n=10 at 0x00), on its first cycle with FIFO non-empty.
REQ-013 SHALL hold data_ready=0 on RND reads while FIFO empty; data_ready=1 combinationally for all other reads.
REQ-014 SHALL return head word without popping for 8/16-bit RND reads; return 0 with data_ready=1 when empty and EN=0.
REQ-015 SHALL accept only 32-bit writes to SEED0..3 into shadow registers; 8/16-bit writes ignored.
REQ-016 SHALL, on SEED3 write, load state from shadows and flush FIFO in that cycle; seed load wins over simultaneous push/pop.
REQ-017 SHALL define CTRL: bit0 EN (reset 1), bit1 IE (reset 0), bits[7:4] THR (reset 0), bit2 JUMP (write-1 strobe, reads 0).
REQ-018 SHALL define STATUS: bits[4:0] level, bit5 empty, bit6 full, bit7 busy.
REQ-019 SHALL assert user_interrupt = IE and (level >= THR) and THR != 0.
REQ-020 SHALL ignore SEED/CTRL writes except EN/IE/THR while busy; RND reads stall (data_ready=0) while busy.

Reset
REQ-021 SHALL on rst_n low asynchronously set state=RESET_SEED, shadows=RESET_SEED, FIFO empty, CTRL=0x01, busy=0, read-done flag clear.
REQ-022 SHALL make first push on first clk edge after rst_n release; data_out, uo_out, user_interrupt reset to 0.
REQ-023 SHALL abort any jump in progress on reset; no partial state retained.

Configuration
REQ-024 SHALL compile jump support only with XOSHIRO_JUMP_EN defined.
REQ-025 SHALL, with XOSHIRO_JUMP_EN, on CTRL.JUMP=1 set busy, flush FIFO, run 128 cycles over constants 0x8764000b, 0xf542d2d3, 0x6fa035c3, 0x77f2db5b (LSB first, XOR-accumulate state where bit set, step every cycle), then load accumulator, clear busy.
REQ-026 SHALL, without XOSHIRO_JUMP_EN, ignore CTRL.JUMP, keep STATUS.busy=0, and contain no jump logic.

Verification
REQ-027 Reset default seed, wait 5 cycles, two 32-bit RND reads -> 0x00000281 then 0x00180387; STATUS level=FIFO_DEPTH after refill.
REQ-028 Read held 4 cycles at 0x00 -> exactly one pop; next read returns next sequence word, no skip.
REQ-029 Write SEED0..3 = 1,2,3,4 mid-stream, read immediately -> stall <=1 cycle, data 0x00000281; old FIFO contents never returned.
REQ-030 EN=0, drain FIFO, 32-bit RND read -> data_out 0, data_ready=1; EN=1 -> refill resumes at next sequence word.
REQ-031 IE=1, THR=3, EN=0, drain to 2 -> user_interrupt 0; EN=1 -> user_interrupt 1 when level reaches 3.
REQ-032 XOSHIRO_JUMP_EN: seed 1,2,3,4, JUMP -> busy exactly 128 cycles, first read matches software reference jump(); without macro busy stays 0, first read 0x00000281.
